// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared pipeline types: branch_status encoding and sequencer states.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        BS_START    = 2'b00,
        BS_REDIRECT = 2'b01,
        BS_DRAIN    = 2'b10,
        BS_RUN      = 2'b11
    } branch_status_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2,
        RETIRE   = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer_if
// Brief    : Control-transfer handshake between the branch stage and the sequencer.
// Revision : 1.0
// ============================================================================
interface branch_sequencer_if;
    import pipeline_pkg::*;

    logic           ctl_valid;
    logic           is_cond_branch;
    logic           take_branch;
    logic           jump_start;
    logic           hold;
    branch_status_t branch_status;
    logic           flush;
    logic           busy;

    modport master (
        output ctl_valid, is_cond_branch, take_branch, jump_start, hold,
        input  branch_status, flush, busy
    );

    modport slave (
        input  ctl_valid, is_cond_branch, take_branch, jump_start, hold,
        output branch_status, flush, busy
    );

endinterface
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer
// Brief    : Redirect/drain/retire sequencer for BRANCH/JAL/JALR.
//            Option macro BRANCH_FAST_NOT_TAKEN_EN: not-taken branches skip to RETIRE.
// Revision : 1.0
// ============================================================================
module branch_sequencer
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    branch_sequencer_if.slave bus
);

    localparam int             CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // hold freezes everything, including acceptance of a new start
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bus.hold) begin
            case (r_state)
                IDLE: begin
                    if (bus.jump_start && bus.ctl_valid) begin
                        w_state_nxt = REDIRECT;
`ifdef BRANCH_FAST_NOT_TAKEN_EN
                        if (bus.is_cond_branch && !bus.take_branch) begin
                            w_state_nxt = RETIRE;
                        end
`endif
                    end
                end
                REDIRECT: begin
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = (FLUSH_CYCLES == 1) ? RETIRE : DRAIN;
                end
                DRAIN: begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = RETIRE;
                    end
                end
                RETIRE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.branch_status = BS_START;
        bus.flush         = 1'b0;
        bus.busy          = 1'b1;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
            end
            REDIRECT: begin
                bus.branch_status = BS_REDIRECT;
                bus.flush         = 1'b1;
            end
            DRAIN: begin
                bus.branch_status = BS_DRAIN;
                bus.flush         = 1'b1;
            end
            RETIRE: begin
                bus.branch_status = BS_RUN;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

`ifndef BRANCH_FAST_NOT_TAKEN_EN
    logic w_unused;
    assign w_unused = &{1'b0, bus.is_cond_branch, bus.take_branch};
`endif

    a_jump_start_needs_valid: assert property (
        @(posedge clock) disable iff (!reset_n) bus.jump_start |-> bus.ctl_valid
    );

endmodule
`default_nettype wire
